id_operand_stage: RTL and testbench

- Decode/operand-fetch stage of the pipelined MIPS core, directly downstream of the register file.
- Drives the register-file read addresses from the IF/ID instruction and forwards results from MEM (and optionally WB).
- Detects hazards that cannot be forwarded and stalls IF.
- Latches operands, extended immediate and register indices into the ID/EX pipeline register, with flush/hold control and a stall-cycle counter.

---
 rtl/mips_pkg.sv | 51 +++++
 rtl/id_operand_stage_if.sv | 53 +++++
 rtl/id_hazard_fwd.sv | 72 +++++++
 rtl/id_operand_stage.sv | 117 +++++++++++
 tb/tb_id_operand_stage.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, ID/EX payload type and immediate-extension helper.
package mips_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned OP_W       = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_SB    = 6'h28;
    localparam logic [OP_W-1:0] OP_SH    = 6'h29;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OP_W-1:0] FN_SLL   = 6'h00;
    localparam logic [OP_W-1:0] FN_SRL   = 6'h02;
    localparam logic [OP_W-1:0] FN_SRA   = 6'h03;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       instr;
        logic [XLEN-1:0]       pc_plus4;
        logic [XLEN-1:0]       rs_val;
        logic [XLEN-1:0]       rt_val;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
    } idex_t;

    // Logical immediates are zero-extended, everything else sign-extended.
    function automatic logic [XLEN-1:0] ext_imm(input logic [OP_W-1:0] op, input logic [15:0] imm16);
        if (op == OP_ANDI || op == OP_ORI || op == OP_XORI) begin
            return {16'h0000, imm16};
        end
        return {{16{imm16[15]}}, imm16};
    endfunction

endpackage

// File: rtl/id_operand_stage_if.sv
// Bus bundle between the ID operand stage and its IF/RF/EX/MEM/WB neighbours.
interface id_operand_stage_if #(
    parameter int unsigned CNT_W = 16
) ();
    import mips_pkg::*;

    logic                  if_valid;
    logic [XLEN-1:0]       if_instr;
    logic [XLEN-1:0]       if_pc_plus4;
    logic [REG_ADDR_W-1:0] rf_addr1;
    logic [REG_ADDR_W-1:0] rf_addr2;
    logic [XLEN-1:0]       rf_data1;
    logic [XLEN-1:0]       rf_data2;
    logic                  ex_wr;
    logic                  ex_memread;
    logic [REG_ADDR_W-1:0] ex_waddr;
    logic                  mem_wr;
    logic                  mem_memread;
    logic [REG_ADDR_W-1:0] mem_waddr;
    logic [XLEN-1:0]       mem_wdata;
    logic                  wb_wr;
    logic [REG_ADDR_W-1:0] wb_waddr;
    logic [XLEN-1:0]       wb_wdata;
    logic                  flush_in;
    logic                  ex_stall_in;
    logic                  stall_out;
    logic                  idex_valid;
    logic [XLEN-1:0]       idex_instr;
    logic [XLEN-1:0]       idex_pc_plus4;
    logic [XLEN-1:0]       idex_rs_val;
    logic [XLEN-1:0]       idex_rt_val;
    logic [XLEN-1:0]       idex_imm;
    logic [REG_ADDR_W-1:0] idex_rs;
    logic [REG_ADDR_W-1:0] idex_rt;
    logic [REG_ADDR_W-1:0] idex_rd;
    logic [CNT_W-1:0]      perf_stall_cnt;

    modport master (
        input  if_valid, if_instr, if_pc_plus4, rf_data1, rf_data2,
               ex_wr, ex_memread, ex_waddr, mem_wr, mem_memread, mem_waddr, mem_wdata,
               wb_wr, wb_waddr, wb_wdata, flush_in, ex_stall_in,
        output rf_addr1, rf_addr2, stall_out, idex_valid, idex_instr, idex_pc_plus4,
               idex_rs_val, idex_rt_val, idex_imm, idex_rs, idex_rt, idex_rd, perf_stall_cnt
    );

    modport slave (
        output if_valid, if_instr, if_pc_plus4, rf_data1, rf_data2,
               ex_wr, ex_memread, ex_waddr, mem_wr, mem_memread, mem_waddr, mem_wdata,
               wb_wr, wb_waddr, wb_wdata, flush_in, ex_stall_in,
        input  rf_addr1, rf_addr2, stall_out, idex_valid, idex_instr, idex_pc_plus4,
               idex_rs_val, idex_rt_val, idex_imm, idex_rs, idex_rt, idex_rd, perf_stall_cnt
    );
endinterface

// File: rtl/id_hazard_fwd.sv
// Combinational source-use decode, producer matching, hazard and forwarding selects.
// ID_WB_BYPASS_EN adds a WB-stage forwarding path for rising-edge register files.
module id_hazard_fwd
    import mips_pkg::*;
(
    input  logic [OP_W-1:0]       op_i,
    input  logic [OP_W-1:0]       funct_i,
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [REG_ADDR_W-1:0] rt_i,
    input  logic                  ex_wr_i,
    input  logic [REG_ADDR_W-1:0] ex_waddr_i,
    input  logic                  mem_wr_i,
    input  logic                  mem_memread_i,
    input  logic [REG_ADDR_W-1:0] mem_waddr_i,
    input  logic                  wb_wr_i,
    input  logic [REG_ADDR_W-1:0] wb_waddr_i,
    output logic                  hazard_c,
    output fwd_sel_e              sel1_c,
    output fwd_sel_e              sel2_c
);

    logic use_rs, use_rt;
    logic ex_hot1, ex_hot2, mem_hot1, mem_hot2, wb_hot1, wb_hot2;

    function automatic logic is_hot(input logic [REG_ADDR_W-1:0] src, input logic wr,
                                    input logic [REG_ADDR_W-1:0] waddr);
        return wr && (src != '0) && (src == waddr);
    endfunction

    function automatic fwd_sel_e pick(input logic mem_hot, input logic memread, input logic wb_hot);
        if (mem_hot) begin
            return memread ? FWD_RF : FWD_MEM;
        end
        return wb_hot ? FWD_WB : FWD_RF;
    endfunction

    always_comb begin
        use_rs = 1'b1;
        use_rt = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                use_rt = 1'b1;
                if (funct_i == FN_SLL || funct_i == FN_SRL || funct_i == FN_SRA) begin
                    use_rs = 1'b0;
                end
            end
            OP_J, OP_JAL, OP_LUI:                 use_rs = 1'b0;
            OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW:  use_rt = 1'b1;
            default: ;
        endcase
    end

    assign ex_hot1  = use_rs && is_hot(rs_i, ex_wr_i, ex_waddr_i);
    assign ex_hot2  = use_rt && is_hot(rt_i, ex_wr_i, ex_waddr_i);
    assign mem_hot1 = use_rs && is_hot(rs_i, mem_wr_i, mem_waddr_i);
    assign mem_hot2 = use_rt && is_hot(rt_i, mem_wr_i, mem_waddr_i);

`ifdef ID_WB_BYPASS_EN
    assign wb_hot1 = use_rs && is_hot(rs_i, wb_wr_i, wb_waddr_i);
    assign wb_hot2 = use_rt && is_hot(rt_i, wb_wr_i, wb_waddr_i);
`else
    logic unused_wb;
    assign unused_wb = ^{wb_wr_i, wb_waddr_i};
    assign wb_hot1   = 1'b0;
    assign wb_hot2   = 1'b0;
`endif

    assign hazard_c = ex_hot1 || ex_hot2 || (mem_memread_i && (mem_hot1 || mem_hot2));
    assign sel1_c   = pick(mem_hot1, mem_memread_i, wb_hot1);
    assign sel2_c   = pick(mem_hot2, mem_memread_i, wb_hot2);

endmodule

// File: rtl/id_operand_stage.sv
// MIPS decode/operand-fetch stage: RF addressing, forwarding, hazard stall and ID/EX register.
// ID_WB_BYPASS_EN enables forwarding of WB results (see id_hazard_fwd).
module id_operand_stage
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    id_operand_stage_if.master bus
);

    logic [REG_ADDR_W-1:0] rs, rt, rd;
    logic                  hazard;
    fwd_sel_e              sel1, sel2;
    logic [XLEN-1:0]       op1, op2;
    logic                  hazard_stall;
    idex_t                 idex_d, idex_q;
    logic [CNT_W-1:0]      cnt_d, cnt_q;

    assign rs = bus.if_instr[25:21];
    assign rt = bus.if_instr[20:16];
    assign rd = bus.if_instr[15:11];

    assign bus.rf_addr1 = rs;
    assign bus.rf_addr2 = rt;

    id_hazard_fwd u_hazard_fwd (
        .op_i          (bus.if_instr[31:26]),
        .funct_i       (bus.if_instr[5:0]),
        .rs_i          (rs),
        .rt_i          (rt),
        .ex_wr_i       (bus.ex_wr),
        .ex_waddr_i    (bus.ex_waddr),
        .mem_wr_i      (bus.mem_wr),
        .mem_memread_i (bus.mem_memread),
        .mem_waddr_i   (bus.mem_waddr),
        .wb_wr_i       (bus.wb_wr),
        .wb_waddr_i    (bus.wb_waddr),
        .hazard_c      (hazard),
        .sel1_c        (sel1),
        .sel2_c        (sel2)
    );

    // Any EX producer stalls regardless of type, so ex_memread carries no extra information.
    logic unused_ex;
    assign unused_ex = bus.ex_memread;

`ifdef ID_WB_BYPASS_EN
    function automatic logic [XLEN-1:0] fwd_mux(input fwd_sel_e sel, input logic [XLEN-1:0] rf_val,
                                                input logic [XLEN-1:0] mem_val, input logic [XLEN-1:0] wb_val);
        case (sel)
            FWD_MEM: return mem_val;
            FWD_WB:  return wb_val;
            default: return rf_val;
        endcase
    endfunction
    assign op1 = fwd_mux(sel1, bus.rf_data1, bus.mem_wdata, bus.wb_wdata);
    assign op2 = fwd_mux(sel2, bus.rf_data2, bus.mem_wdata, bus.wb_wdata);
`else
    logic unused_wb_data;
    assign unused_wb_data = ^bus.wb_wdata;
    assign op1 = (sel1 == FWD_MEM) ? bus.mem_wdata : bus.rf_data1;
    assign op2 = (sel2 == FWD_MEM) ? bus.mem_wdata : bus.rf_data2;
`endif

    assign hazard_stall  = bus.if_valid && hazard && !bus.flush_in;
    assign bus.stall_out = bus.ex_stall_in || hazard_stall;

    // ID/EX next state: flush, then downstream hold, then bubble or load.
    always_comb begin
        idex_d = idex_q;
        cnt_d  = cnt_q;
        if (bus.flush_in) begin
            idex_d = '0;
        end else if (!bus.ex_stall_in) begin
            if (bus.if_valid && !hazard) begin
                idex_d.valid    = 1'b1;
                idex_d.instr    = bus.if_instr;
                idex_d.pc_plus4 = bus.if_pc_plus4;
                idex_d.rs_val   = op1;
                idex_d.rt_val   = op2;
                idex_d.imm      = ext_imm(bus.if_instr[31:26], bus.if_instr[15:0]);
                idex_d.rs       = rs;
                idex_d.rt       = rt;
                idex_d.rd       = rd;
            end else begin
                idex_d = '0;
            end
            if (hazard_stall && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idex_q <= '0;
            cnt_q  <= '0;
        end else begin
            idex_q <= idex_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.idex_valid     = idex_q.valid;
    assign bus.idex_instr     = idex_q.instr;
    assign bus.idex_pc_plus4  = idex_q.pc_plus4;
    assign bus.idex_rs_val    = idex_q.rs_val;
    assign bus.idex_rt_val    = idex_q.rt_val;
    assign bus.idex_imm       = idex_q.imm;
    assign bus.idex_rs        = idex_q.rs;
    assign bus.idex_rt        = idex_q.rt;
    assign bus.idex_rd        = idex_q.rd;
    assign bus.perf_stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Randomized + directed bench for id_operand_stage against a rule-level reference model.
module tb_id_operand_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_operand_stage_if #(.CNT_W(16)) bus ();
    id_operand_stage #(.CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    // Reference ID/EX contents and stall counter
    logic        e_valid;
    logic [31:0] e_instr, e_pc, e_rsv, e_rtv, e_imm;
    logic [4:0]  e_rs, e_rt, e_rd;
    logic [15:0] e_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit reads_rs(input logic [31:0] i);
        if (i[31:26] == 6'd0) return !(i[5:0] inside {6'd0, 6'd2, 6'd3});
        return !(i[31:26] inside {6'd2, 6'd3, 6'd15});
    endfunction

    function automatic bit reads_rt(input logic [31:0] i);
        return i[31:26] inside {6'd0, 6'd4, 6'd5, 6'd40, 6'd41, 6'd43};
    endfunction

    function automatic bit produces(input logic [4:0] r, input logic wr, input logic [4:0] a);
        return wr && (r != 5'd0) && (r == a);
    endfunction

    function automatic bit blocked(input logic [4:0] r, input bit used);
        return used && (produces(r, bus.ex_wr, bus.ex_waddr) ||
                        (bus.mem_memread && produces(r, bus.mem_wr, bus.mem_waddr)));
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] r, input bit used, input logic [31:0] rfd);
        if (used && produces(r, bus.mem_wr, bus.mem_waddr)) return bus.mem_memread ? rfd : bus.mem_wdata;
`ifdef ID_WB_BYPASS_EN
        if (used && produces(r, bus.wb_wr, bus.wb_waddr)) return bus.wb_wdata;
`endif
        return rfd;
    endfunction

    task automatic model_clear();
        e_valid = 1'b0; e_instr = '0; e_pc = '0; e_rsv = '0; e_rtv = '0;
        e_imm = '0; e_rs = '0; e_rt = '0; e_rd = '0;
    endtask

    task automatic check_regs();
        check("idex_valid", 64'(bus.idex_valid), 64'(e_valid));
        check("idex_instr", 64'(bus.idex_instr), 64'(e_instr));
        check("idex_pc_plus4", 64'(bus.idex_pc_plus4), 64'(e_pc));
        check("idex_rs_val", 64'(bus.idex_rs_val), 64'(e_rsv));
        check("idex_rt_val", 64'(bus.idex_rt_val), 64'(e_rtv));
        check("idex_imm", 64'(bus.idex_imm), 64'(e_imm));
        check("idex_rs", 64'(bus.idex_rs), 64'(e_rs));
        check("idex_rt", 64'(bus.idex_rt), 64'(e_rt));
        check("idex_rd", 64'(bus.idex_rd), 64'(e_rd));
        check("perf_stall_cnt", 64'(bus.perf_stall_cnt), 64'(e_cnt));
    endtask

    // Check combinational outputs, clock once, advance the model, check the ID/EX register.
    task automatic step();
        logic [31:0] i, v1, v2, imm;
        bit u1, u2, hz;
        i  = bus.if_instr;
        u1 = reads_rs(i);
        u2 = reads_rt(i);
        hz = bus.if_valid && (blocked(i[25:21], u1) || blocked(i[20:16], u2));
        v1 = operand(i[25:21], u1, bus.rf_data1);
        v2 = operand(i[20:16], u2, bus.rf_data2);
        imm = (i[31:26] inside {6'h0C, 6'h0D, 6'h0E}) ? {16'h0, i[15:0]} : {{16{i[15]}}, i[15:0]};
        #1;
        check("stall_out", 64'(bus.stall_out), 64'(bus.ex_stall_in || (hz && !bus.flush_in)));
        check("rf_addr1", 64'(bus.rf_addr1), 64'(i[25:21]));
        check("rf_addr2", 64'(bus.rf_addr2), 64'(i[20:16]));
        @(posedge clk);
        if (bus.flush_in) model_clear();
        else if (!bus.ex_stall_in) begin
            if (hz && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
            if (hz || !bus.if_valid) model_clear();
            else begin
                e_valid = 1'b1; e_instr = i; e_pc = bus.if_pc_plus4; e_rsv = v1; e_rtv = v2;
                e_imm = imm; e_rs = i[25:21]; e_rt = i[20:16]; e_rd = i[15:11];
            end
        end
        #1;
        check_regs();
    endtask

    task automatic idle();
        bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc_plus4 = '0;
        bus.rf_data1 = $urandom; bus.rf_data2 = $urandom;
        bus.ex_wr = 1'b0; bus.ex_memread = 1'b0; bus.ex_waddr = '0;
        bus.mem_wr = 1'b0; bus.mem_memread = 1'b0; bus.mem_waddr = '0; bus.mem_wdata = $urandom;
        bus.wb_wr = 1'b0; bus.wb_waddr = '0; bus.wb_wdata = $urandom;
        bus.flush_in = 1'b0; bus.ex_stall_in = 1'b0;
    endtask

    task automatic issue(input logic [31:0] instr);
        bus.if_valid = 1'b1; bus.if_instr = instr; bus.if_pc_plus4 = $urandom;
        bus.rf_data1 = $urandom; bus.rf_data2 = $urandom;
    endtask

    logic [5:0] ops [14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C,
                             6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h28, 6'h29, 6'h2B};
    logic [5:0] fns [5]  = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h22};

    initial begin
        reset = 1'b0;
        idle();
        e_cnt = '0;
        model_clear();
        #3;
        check_regs();
        #9 reset = 1'b1;
        @(posedge clk); #1;

        // RAW on EX producer: one bubble, then load once EX clears
        issue(32'h00221820); bus.ex_wr = 1'b1; bus.ex_waddr = 5'd1;
        step();
        check("t1_cnt", 64'(bus.perf_stall_cnt), 64'd1);
        bus.ex_wr = 1'b0;
        step();

        // MEM ALU result forwarded to rt
        issue(32'h00221820); bus.mem_wr = 1'b1; bus.mem_waddr = 5'd2; bus.mem_wdata = 32'hDEADBEEF;
        step();
        check("t2_rt_fwd", 64'(bus.idex_rt_val), 64'h0DEADBEEF);

        // Load-use: two bubbles then register-file value
        idle(); issue(32'h00A13020);
        bus.ex_wr = 1'b1; bus.ex_memread = 1'b1; bus.ex_waddr = 5'd5;
        step();
        bus.ex_wr = 1'b0; bus.ex_memread = 1'b0;
        bus.mem_wr = 1'b1; bus.mem_memread = 1'b1; bus.mem_waddr = 5'd5;
        step();
        bus.mem_wr = 1'b0; bus.mem_memread = 1'b0;
        step();
        check("lu_cnt", 64'(bus.perf_stall_cnt), 64'd3);

        // Immediate extension and writes to $0
        idle(); issue(32'h34048001); bus.ex_wr = 1'b1; bus.ex_waddr = 5'd0;
        step();
        check("ori_imm", 64'(bus.idex_imm), 64'h00008001);
        issue(32'h20048001);
        step();
        check("addi_imm", 64'(bus.idex_imm), 64'hFFFF8001);

        // Flush beats hazard
        idle(); issue(32'h00221820); bus.ex_wr = 1'b1; bus.ex_waddr = 5'd1; bus.flush_in = 1'b1;
        step();
        check("flush_cnt", 64'(bus.perf_stall_cnt), 64'd3);

        // Downstream hold for three cycles
        idle(); issue(32'h34048001);
        step();
        for (int k = 0; k < 3; k++) begin
            issue($urandom); bus.ex_stall_in = 1'b1;
            step();
        end
        check("hold_instr", 64'(bus.idex_instr), 64'h34048001);

        // Asynchronous reset mid-run
        #2 reset = 1'b0;
        model_clear(); e_cnt = '0;
        #1 check_regs();
        #1 reset = 1'b1;
        idle();

        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 13)];
            ins[25:21] = 5'($urandom_range(0, 3));
            ins[20:16] = 5'($urandom_range(0, 3));
            if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 4)];
            issue(ins);
            bus.if_valid    = ($urandom_range(0, 3) != 0);
            bus.ex_wr       = 1'($urandom);
            bus.ex_memread  = 1'($urandom);
            bus.ex_waddr    = 5'($urandom_range(0, 3));
            bus.mem_wr      = 1'($urandom);
            bus.mem_memread = ($urandom_range(0, 2) == 0);
            bus.mem_waddr   = 5'($urandom_range(0, 3));
            bus.mem_wdata   = $urandom;
            bus.wb_wr       = 1'($urandom);
            bus.wb_waddr    = 5'($urandom_range(0, 3));
            bus.wb_wdata    = $urandom;
            bus.flush_in    = ($urandom_range(0, 7) == 0);
            bus.ex_stall_in = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
